sica_z_loader: RTL

SICA_Z_LOADER -- requirements
Module: sica_z_loader

---
 rtl/sica_z_loader.sv | 112 +++++++++++
 1 files changed

// File: rtl/sica_z_loader.sv
// Serial-to-parallel sample loader: captures a channel-major serial stream into a
// DIM x SAMPLES buffer and serves whole sample vectors (all channels) per read.
module sica_z_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int DIM        = 5,
  parameter int SAMPLES    = 1024,
  parameter int LOGM       = 10
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic                       load_data,
  input  logic [DATA_WIDTH-1:0]      serial_z_in,
  input  logic                       serial_z_valid,
  input  logic                       clear,
  input  logic                       rd_en,
  input  logic [LOGM-1:0]            rd_addr,
  output logic                       load_done,
  output logic                       rd_valid,
  output logic [DATA_WIDTH*DIM-1:0]  rd_vec,
  output logic [LOGM+3:0]            word_cnt,
  output logic                       overflow
);

  localparam int CHW  = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int IDXW = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
  localparam logic [LOGM+3:0] TOTAL    = (LOGM+4)'(DIM * SAMPLES);
  localparam logic [LOGM:0]   SAMP_LIM = (LOGM+1)'(SAMPLES);

  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

  state_t                  r_state;
  logic [CHW-1:0]          r_ch;
  logic [LOGM-1:0]         r_smp;
  logic [DATA_WIDTH-1:0]   r_mem [SAMPLES][DIM];

  logic                    w_accept;
  logic                    w_last_smp;
  logic                    w_last_ch;
  logic                    w_rd_ok;
  logic                    w_addr_ok;
  logic [IDXW-1:0]         w_wr_idx;
  logic [IDXW-1:0]         w_rd_idx;
  logic [DATA_WIDTH*DIM-1:0] w_row;

  assign w_accept   = serial_z_valid && load_data && !clear && (r_state != FULL);
  assign w_last_smp = (r_smp == LOGM'(SAMPLES - 1));
  assign w_last_ch  = (r_ch == CHW'(DIM - 1));
  assign w_rd_ok    = rd_en && (r_state == FULL);
  assign w_addr_ok  = ({1'b0, rd_addr} < SAMP_LIM);
  assign w_wr_idx   = r_smp[IDXW-1:0];
  assign w_rd_idx   = rd_addr[IDXW-1:0];

  // NOTE: the sample buffer has no reset branch; its contents are don't-care until
  // written, and leaving reset off keeps it mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[w_wr_idx][r_ch] <= serial_z_in;
  end

  // All channels of one sample sit in one row, so a read is a single row fetch.
  always_comb begin
    // NOTE: default assignment first so no path through this block infers a latch.
    w_row = '0;
    for (int c = 0; c < DIM; c++) begin
      w_row[c*DATA_WIDTH +: DATA_WIDTH] = r_mem[w_rd_idx][CHW'(c)];
    end
  end

  // NOTE: every state register below uses <= so all updates see pre-edge values.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state   <= IDLE;
      r_ch      <= '0;
      r_smp     <= '0;
      word_cnt  <= '0;
      load_done <= 1'b0;
      overflow  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_vec    <= '0;
    end else if (clear) begin
      // Restart wins over any concurrent word or read; buffer data is kept.
      r_state   <= IDLE;
      r_ch      <= '0;
      r_smp     <= '0;
      word_cnt  <= '0;
      load_done <= 1'b0;
      overflow  <= 1'b0;
      rd_valid  <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_last_smp) begin
          r_smp <= '0;
          r_ch  <= r_ch + CHW'(1);
        end else begin
          r_smp <= r_smp + LOGM'(1);
        end
        if (word_cnt != TOTAL) word_cnt <= word_cnt + (LOGM+4)'(1);
        if (w_last_smp && w_last_ch) begin
          r_state   <= FULL;
          load_done <= 1'b1;
        end else begin
          r_state <= LOAD;
        end
      end

      if ((r_state == FULL) && serial_z_valid && load_data) overflow <= 1'b1;

      rd_valid <= w_rd_ok;
      if (w_rd_ok) rd_vec <= w_addr_ok ? w_row : '0;
    end
  end

endmodule
